// File: rtl/debounce2_if.sv
// Debounce2 channel bundle: raw inputs in, debounced levels and rising-edge pulses out.
interface debounce2_if;
  logic x0;
  logic x1;
  logic z0;
  logic z1;
  logic p0;
  logic p1;

  modport master (output x0, output x1, input z0, input z1, input p0, input p1);
  modport slave  (input x0, input x1, output z0, output z1, output p0, output p1);
endinterface

// File: rtl/debounce2.sv
// Two independent pushbutton debouncers: 2-flop synchronizer, stability counter,
// registered level output and a one-cycle pulse on each accepted rising level.
module debounce2 #(
  parameter int unsigned DB_CYCLES = 120000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  debounce2_if.slave  bus
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0] x_s;
  logic [1:0] z_s;
  logic [1:0] p_s;

  assign x_s    = {bus.x1, bus.x0};
  assign bus.z0 = z_s[0];
  assign bus.z1 = z_s[1];
  assign bus.p0 = p_s[0];
  assign bus.p1 = p_s[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             meta_q, meta_d;
    logic             s_q, s_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;
    logic             p_q, p_d;

    // Next-state: synchronizer shift, then count consecutive mismatches between s and z.
    always_comb begin
      meta_d  = x_s[ch];
      s_d     = meta_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      p_d     = 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (s_q != z_q) begin
            if (cnt_q == CNT_LAST) begin
              z_d   = s_q;
              p_d   = s_q;
              cnt_d = '0;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_COUNTING;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_COUNTING: begin
          // Any agreement between s and z throws the partial count away.
          if (s_q == z_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            z_d     = s_q;
            p_d     = s_q;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q  <= 1'b0;
        s_q     <= 1'b0;
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        z_q     <= 1'b0;
        p_q     <= 1'b0;
      end else begin
        meta_q  <= meta_d;
        s_q     <= s_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        z_q     <= z_d;
        p_q     <= p_d;
      end
    end

    assign z_s[ch] = z_q;
    assign p_s[ch] = p_q;
  end

endmodule

// File: tb/tb_debounce2.sv
// Self-checking bench for debounce2 (DB_CYCLES = 4): hand tables, corner sequences
// and a randomized run against a sample-window reference model.
module tb_debounce2;
  localparam int DB = 4;

  logic clk;
  logic clk_en;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  debounce2_if bus ();

  debounce2 #(.DB_CYCLES(DB), .CNT_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Reference model: z flips once the last DB synchronized samples (raw samples
  // taken 2..DB+1 edges ago) all disagree with the current z.
  logic hist [2][DB+2];
  logic mz [2];
  logic mp [2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < DB + 2; i++) hist[c][i] = 1'b0;
      mz[c] = 1'b0;
      mp[c] = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic r0, input logic r1);
    logic r [2];
    logic flip;
    r[0] = r0;
    r[1] = r1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < DB + 1; i++) hist[c][i] = hist[c][i+1];
      hist[c][DB+1] = r[c];
      flip = 1'b1;
      for (int i = 0; i < DB; i++) if (hist[c][i] == mz[c]) flip = 1'b0;
      mp[c] = flip && !mz[c];
      if (flip) mz[c] = ~mz[c];
    end
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ez0, input logic ez1,
                         input logic ep0, input logic ep1);
    chk({name, ".z0"}, bus.z0, ez0);
    chk({name, ".z1"}, bus.z1, ez1);
    chk({name, ".p0"}, bus.p0, ep0);
    chk({name, ".p1"}, bus.p1, ep1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.x0, bus.x1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_all("reset_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic x0, x1;
    logic z0, z1, p0, p1;
  } vec_t;

  vec_t tbl [16];

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    bus.x0 = 1'b1;
    bus.x1 = 1'b1;
    model_reset();

    // Clean press on ch0, then simultaneous release ch0 / press ch1.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{x0: (i < 8), x1: (i >= 8), z0: 1'b0, z1: 1'b0, p0: 1'b0, p1: 1'b0};
    end
    for (int i = 5; i < 13; i++) tbl[i].z0 = 1'b1;
    tbl[5].p0 = 1'b1;
    for (int i = 13; i < 16; i++) tbl[i].z1 = 1'b1;
    tbl[13].p1 = 1'b1;

    // Reset with clock stopped and inputs high.
    #2 rst_n = 1'b0;
    #2 chk_all("reset_noclk", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.x0 = 1'b0;
    bus.x1 = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.x0 = tbl[i].x0;
      bus.x1 = tbl[i].x1;
      tick();
      chk_all($sformatf("tbl[%0d]", i), tbl[i].z0, tbl[i].z1, tbl[i].p0, tbl[i].p1);
    end

    // Glitch of 3 edges must be rejected, and the count must restart from zero.
    bus.x1 = 1'b0;
    bus.x0 = 1'b0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      bus.x0 = (k <= 3);
      tick();
      chk($sformatf("glitch.z0[%0d]", k), bus.z0, 1'b0);
      chk($sformatf("glitch.p0[%0d]", k), bus.p0, 1'b0);
    end
    bus.x0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("after_glitch.z0[%0d]", k), bus.z0, k >= 6);
      chk($sformatf("after_glitch.p0[%0d]", k), bus.p0, k == 6);
    end

    // Bounce: toggle for 10 edges, final 0->1 sampled at edge 11.
    bus.x0 = 1'b0;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      bus.x0 = (k <= 10) ? logic'(k % 2) : 1'b1;
      tick();
      chk($sformatf("bounce.z0[%0d]", k), bus.z0, k >= 16);
      chk($sformatf("bounce.p0[%0d]", k), bus.p0, k == 16);
    end

    // Reset in the middle of a count, raw input stays high.
    bus.x0 = 1'b0;
    do_reset();
    bus.x0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("midcnt.pre.z0[%0d]", k), bus.z0, 1'b0);
    end
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("midcnt.z0[%0d]", k), bus.z0, k >= 6);
      chk($sformatf("midcnt.p0[%0d]", k), bus.p0, k == 6);
    end

    // Randomized run against the reference model.
    bus.x0 = 1'b0;
    bus.x1 = 1'b0;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) bus.x0 = ~bus.x0;
      if ($urandom_range(0, 5) == 0) bus.x1 = ~bus.x1;
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
      chk_all($sformatf("rand[%0d]", k), mz[0], mz[1], mp[0], mp[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce2.md
DEBOUNCE2 -- requirements
Module: debounce2

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 120000, meaning the number of consecutive stable cycles required to accept a new level (10 ms at 12 MHz); legal range 1 to 2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 17, meaning the debounce counter width.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 x0  input  1  raw, asynchronous, bouncing input, channel 0 (pushbutton).
REQ-006 x1  input  1  raw, asynchronous, bouncing input, channel 1 (pushbutton).
REQ-007 z0  output  1  debounced level, channel 0; drives downstream gate input.
REQ-008 z1  output  1  debounced level, channel 1; drives downstream gate input.
REQ-009 p0  output  1  one-cycle pulse on each z0 0->1 transition.
REQ-010 p1  output  1  one-cycle pulse on each z1 0->1 transition.

Function
REQ-011 The two channels SHALL be identical and fully independent; no cross-channel state is permitted.
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchronizer; the synchronized level is s.
REQ-013 Each channel SHALL have two states: STABLE (s == z, counter held at 0) and COUNTING (s != z).
REQ-014 In COUNTING, the counter SHALL increment by 1 per cycle while s != z.
REQ-015 On any cycle where s == z, the counter SHALL clear to 0 and the channel SHALL return to STABLE (glitch rejection).
REQ-016 On the edge where s != z and counter == DB_CYCLES-1, z SHALL take the value of s and the counter SHALL clear to 0; the counter SHALL never wrap or exceed DB_CYCLES-1.
REQ-017 Latency: for a raw level held stable, z SHALL change on the (DB_CYCLES+2)th rising edge, counting the first edge that samples the new raw level.
REQ-018 With DB_CYCLES = 1, z SHALL change on the first edge at which the mismatch is seen (3rd edge overall).
REQ-019 z0, z1, p0, p1 SHALL all be registered outputs, with no combinational path from x0/x1.
REQ-020 p SHALL assert on the same edge that z goes 0->1 and deassert on the following edge.
REQ-021 p SHALL never assert on a 1->0 transition of z.
REQ-022 Simultaneous transitions on x0 and x1 SHALL each be debounced with identical latency.

Reset
REQ-023 While rst_n = 0, all synchronizer flops, counters, z0, z1, p0 and p1 SHALL be 0 immediately, independent of clk.
REQ-024 Reset asserted mid-count SHALL discard the partial count.
REQ-025 After rst_n rises, a raw input already held at 1 SHALL be accepted as a new level: z rises after the REQ-017 latency and p pulses.

Verification (DB_CYCLES = 4)
REQ-026 Reset check: hold rst_n = 0 with x0 = x1 = 1 and clk stopped -> z0, z1, p0, p1 all read 0.
REQ-027 Clean press: x0 0->1 and held -> z0 = 1 on the 6th edge; p0 = 1 for exactly that one cycle.
REQ-028 Glitch rejection: x0 high for 3 edges, then low -> z0 and p0 never assert; counter returns to 0.
REQ-029 Bounce: x0 toggles every cycle for 10 cycles, then held at 1 -> z0 rises on the 6th edge after the final transition; exactly one p0 pulse.
REQ-030 Release and independence: with z0 = 1, drive x0 1->0 while x1 0->1 on the same edge -> z0 falls and z1 rises, both on the 6th edge; p1 pulses once; p0 stays 0.
REQ-031 Reset mid-count: x0 = 1 held; pulse rst_n low after 4 edges -> z0 = 0; after release, z0 rises on the 6th edge after rst_n deasserts.
